// File: rtl/conv_encoder_param.sv
// Frame-based convolutional encoder with per-frame rate, constraint length and generators.
// Each accepted bit yields one symbol a cycle later; K-1 zero tail bits then flush the trellis.
module conv_encoder_param #(
  parameter int MAX_CODE_RATE = 3,
  parameter int MAX_K         = 7,
  parameter int FRAME_LEN     = 16
) (
  input  logic                               sys_clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [1:0]                         i_code_rate,
  input  logic [$clog2(MAX_K+1)-1:0]         i_k_sel,
  input  logic [MAX_CODE_RATE*MAX_K-1:0]     i_poly,
  input  logic                               i_start,
  input  logic                               i_encoder_bit,
  input  logic                               i_bit_valid,
  output logic                               o_bit_ready,
  output logic [MAX_CODE_RATE-1:0]           o_encoder_data,
  output logic                               o_data_valid,
  output logic                               o_encoder_done,
  output logic                               o_busy,
  output logic                               o_cfg_err
);
  localparam int KW = $clog2(MAX_K+1);
  localparam int CW = $clog2(FRAME_LEN+1);
  localparam int PW = MAX_CODE_RATE*MAX_K;

  typedef enum logic [1:0] {IDLE, DATA, TAIL, DONE} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               n_q, n_d;
  logic [KW-1:0]            k_q, k_d;
  logic [PW-1:0]            poly_q, poly_d;
  logic [MAX_K-2:0]         shreg_q, shreg_d;
  logic [CW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [KW-1:0]            tail_cnt_q, tail_cnt_d;
  logic [MAX_CODE_RATE-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     done_q, done_d;
  logic                     cfg_err_q, cfg_err_d;

  logic                     cfg_legal;
  logic                     accept;
  logic                     enc_in;
  logic [MAX_K-1:0]         k_mask;
  logic [MAX_K-1:0]         taps;
  logic [MAX_CODE_RATE-1:0] sym;

  assign cfg_legal = (i_code_rate >= 2'd2) && (int'(i_code_rate) <= MAX_CODE_RATE) &&
                     (int'(i_k_sel) >= 3) && (int'(i_k_sel) <= MAX_K);

  assign o_bit_ready = en && (state_q == DATA);
  assign accept      = o_bit_ready && i_bit_valid;
  assign enc_in      = (state_q == DATA) ? i_encoder_bit : 1'b0;
  assign taps        = {shreg_q, enc_in};

  // Generator taps at or beyond K are cleared when latched, so older history never leaks in.
  for (genvar gi = 0; gi < MAX_K; gi++) begin : g_kmask
    assign k_mask[gi] = (KW'(gi) < i_k_sel);
  end

  for (genvar gi = 0; gi < MAX_CODE_RATE; gi++) begin : g_sym
    assign sym[gi] = (2'(gi) < n_q) && (^(poly_q[gi*MAX_K +: MAX_K] & taps));
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    k_d        = k_q;
    poly_d     = poly_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    tail_cnt_d = tail_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    cfg_err_d  = cfg_err_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (cfg_legal) begin
            n_d        = i_code_rate;
            k_d        = i_k_sel;
            poly_d     = i_poly & {MAX_CODE_RATE{k_mask}};
            shreg_d    = '0;
            bit_cnt_d  = '0;
            tail_cnt_d = '0;
            cfg_err_d  = 1'b0;
            state_d    = DATA;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept) begin
          data_d    = sym;
          valid_d   = 1'b1;
          shreg_d   = taps[MAX_K-2:0];
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(FRAME_LEN-1)) state_d = TAIL;
        end
      end
      TAIL: begin
        data_d     = sym;
        valid_d    = 1'b1;
        shreg_d    = taps[MAX_K-2:0];
        tail_cnt_d = tail_cnt_q + KW'(1);
        if (tail_cnt_q == k_q - KW'(2)) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      k_q        <= '0;
      poly_q     <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      tail_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else if (en) begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      poly_q     <= poly_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Pulses are masked while frozen so a held register cannot repeat a symbol.
  assign o_encoder_data = data_q;
  assign o_data_valid   = valid_q && en;
  assign o_encoder_done = done_q && en;
  assign o_busy         = (state_q != IDLE);
  assign o_cfg_err      = cfg_err_q;

endmodule
